uart_prog_loader: RTL

// Initiator side of the UART-programmer memory-load interface. Takes the byte stream from the

---
 rtl/uart_prog_loader.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// UART programmer load-frame parser: assembles little-endian words from the
// rx byte stream and issues single-cycle memory write strobes.
module uart_prog_loader #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         ADR_W       = 14,
    parameter int         TIMEOUT_CYC = 1_000_000
) (
    input  logic             upg_clk_i,
    input  logic             upg_rst_n_i,
    input  logic             rx_vld_i,
    input  logic [7:0]       rx_byte_i,
    output logic             upg_wen_o,
    output logic [ADR_W:0]   upg_adr_o,
    output logic [31:0]      upg_dat_o,
    output logic             upg_done_o,
    output logic             upg_err_o,
    output logic             busy_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_CNT = 17'(2 ** ADR_W);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] IDLE_SAT = TW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_SYNC,
        S_TGT,
        S_CNT_L,
        S_CNT_H,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            sel_q;
    logic [15:0]     cnt_q;
    logic [15:0]     wcnt_q;
    logic [1:0]      bidx_q;
    logic [31:0]     word_q;
    logic [7:0]      acc_q;
    logic [TW-1:0]   idle_q;
    logic            wen_q;
    logic [ADR_W:0]  adr_q;
    logic [31:0]     dat_q;
    logic            done_q;
    logic            err_q;

    logic            busy;
    logic            timeout;
    logic            err_set;
    logic            fire;
    logic [15:0]     cnt_full;
    logic [31:0]     word_nxt;

    assign busy     = (state_q != S_SYNC) && (state_q != S_DONE);
    assign timeout  = busy && !rx_vld_i && (idle_q == IDLE_LAST);
    assign cnt_full = {rx_byte_i, cnt_q[7:0]};
    assign word_nxt = {rx_byte_i, word_q[31:8]};

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        fire    = 1'b0;
        if (timeout) begin
            state_d = S_SYNC;
            err_set = 1'b1;
        end else if (rx_vld_i) begin
            unique case (state_q)
                S_SYNC: begin
                    if (rx_byte_i == SYNC_BYTE) state_d = S_TGT;
                end
                S_TGT: begin
                    if (rx_byte_i == 8'h00 || rx_byte_i == 8'h01) begin
                        state_d = S_CNT_L;
                    end else if (rx_byte_i == 8'hFF) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SYNC;
                        err_set = 1'b1;
                    end
                end
                S_CNT_L: state_d = S_CNT_H;
                S_CNT_H: begin
                    if (cnt_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else if ({1'b0, cnt_full} > MAX_CNT) begin
                        state_d = S_SYNC;
                        err_set = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bidx_q == 2'd3) begin
                        fire = 1'b1;
                        if (wcnt_q + 16'd1 == cnt_q) state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (rx_byte_i != acc_q) err_set = 1'b1;
                    state_d = S_SYNC;
                end
                S_DONE: state_d = S_DONE;
                default: state_d = S_SYNC;
            endcase
        end
    end

    always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
        if (!upg_rst_n_i) begin
            state_q <= S_SYNC;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            acc_q   <= '0;
            idle_q  <= '0;
            wen_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= fire;
            if (rx_vld_i) idle_q <= '0;
            else if (idle_q != IDLE_SAT) idle_q <= idle_q + 1'b1;
            if (err_set) err_q <= 1'b1;
            if (state_d == S_DONE) done_q <= 1'b1;
            // every return to S_SYNC starts the next frame from a clean slate
            if (state_d == S_SYNC) begin
                bidx_q <= '0;
                wcnt_q <= '0;
                acc_q  <= '0;
            end else if (rx_vld_i) begin
                case (state_q)
                    S_TGT:   sel_q <= rx_byte_i[0];
                    S_CNT_L: cnt_q[7:0] <= rx_byte_i;
                    S_CNT_H: cnt_q[15:8] <= rx_byte_i;
                    S_DATA: begin
                        word_q <= word_nxt;
                        acc_q  <= acc_q ^ rx_byte_i;
                        bidx_q <= bidx_q + 2'd1;
                        if (fire) wcnt_q <= wcnt_q + 16'd1;
                    end
                    default: ;
                endcase
            end
            if (fire) begin
                adr_q <= {sel_q, wcnt_q[ADR_W-1:0]};
                dat_q <= word_nxt;
            end
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;
    assign busy_o     = busy;

endmodule
